// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered hex value, one digit
// per SCAN_DIV-cycle slot, emitting {segments, select} words for a serializer.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 200
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Disp_data,
    input  logic [7:0]  Dp_mask,
    input  logic [7:0]  Blank_mask,
    input  logic        Wr_en,
    output logic [15:0] Data,
    output logic        S_EN,
    output logic [2:0]  Digit_idx,
    output logic        Frame_done,
    output logic        Pending
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       PTR_LAST = 3'(DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
    function automatic logic [6:0] hexseg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code[6:0];
    endfunction

    logic [CNT_W-1:0] scan_cnt_reg;
    logic [2:0]       digit_ptr_reg;
    logic [31:0]      shadow_data_reg, active_data_reg;
    logic [7:0]       shadow_dp_reg, active_dp_reg;
    logic [7:0]       shadow_blank_reg, active_blank_reg;
    logic             pending_reg;
    logic [15:0]      data_reg;
    logic             s_en_reg;
    logic [2:0]       digit_idx_reg;
    logic             frame_done_reg;

    logic        tick;
    logic        commit_now;
    logic [31:0] src_data;
    logic [7:0]  src_dp;
    logic [7:0]  src_blank;
    logic [15:0] word_tbl [8];
    logic [15:0] word_next;

    assign tick       = (scan_cnt_reg == CNT_LAST);
    assign commit_now = tick && (digit_ptr_reg == 3'd0) && pending_reg;

    // Digit 0 of a committing tick must already come from the new value.
    assign src_data  = commit_now ? shadow_data_reg  : active_data_reg;
    assign src_dp    = commit_now ? shadow_dp_reg    : active_dp_reg;
    assign src_blank = commit_now ? shadow_blank_reg : active_blank_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            localparam logic [7:0] SEL = ~(8'b1 << gi);
            if (gi < DIGITS) begin : g_live
                assign word_tbl[gi] = {src_blank[gi] ? 8'hFF
                                                     : {~src_dp[gi], hexseg(src_data[4*gi +: 4])},
                                       SEL};
            end else begin : g_unused
                assign word_tbl[gi] = 16'hFFFF;
            end
        end
    endgenerate

    assign word_next = word_tbl[digit_ptr_reg];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            scan_cnt_reg     <= '0;
            digit_ptr_reg    <= 3'd0;
            shadow_data_reg  <= 32'd0;
            shadow_dp_reg    <= 8'd0;
            shadow_blank_reg <= 8'd0;
            active_data_reg  <= 32'd0;
            active_dp_reg    <= 8'd0;
            active_blank_reg <= 8'd0;
            pending_reg      <= 1'b0;
            data_reg         <= 16'hFFFF;
            s_en_reg         <= 1'b0;
            digit_idx_reg    <= 3'd0;
            frame_done_reg   <= 1'b0;
        end else begin
            s_en_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            scan_cnt_reg   <= tick ? '0 : scan_cnt_reg + CNT_W'(1);

            if (tick) begin
                data_reg       <= word_next;
                s_en_reg       <= 1'b1;
                digit_idx_reg  <= digit_ptr_reg;
                frame_done_reg <= (digit_ptr_reg == PTR_LAST);
                digit_ptr_reg  <= (digit_ptr_reg == PTR_LAST) ? 3'd0 : digit_ptr_reg + 3'd1;
                if (commit_now) begin
                    active_data_reg  <= shadow_data_reg;
                    active_dp_reg    <= shadow_dp_reg;
                    active_blank_reg <= shadow_blank_reg;
                    pending_reg      <= 1'b0;
                end
            end

            // A write on the commit edge lands after the old shadow was taken.
            if (Wr_en) begin
                shadow_data_reg  <= Disp_data;
                shadow_dp_reg    <= Dp_mask;
                shadow_blank_reg <= Blank_mask;
                pending_reg      <= 1'b1;
            end
        end
    end

    assign Data       = data_reg;
    assign S_EN       = s_en_reg;
    assign Digit_idx  = digit_idx_reg;
    assign Frame_done = frame_done_reg;
    assign Pending    = pending_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench: an 8-digit and a 4-digit instance, both with SCAN_DIV=8.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic [31:0] disp_data = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic [7:0]  blank_mask = 8'd0;
    logic        wr_en = 1'b0;
    logic        wr4 = 1'b0;

    logic [15:0] data8, data4;
    logic        s_en8, s_en4;
    logic [2:0]  idx8, idx4;
    logic        fd8, fd4;
    logic        pend8, pend4;

    int checks = 0;
    int failures = 0;

    localparam logic [7:0] SEL_TBL [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                                             8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(8)) dut8 (
        .Clk(clk), .Rst(rst), .Disp_data(disp_data), .Dp_mask(dp_mask),
        .Blank_mask(blank_mask), .Wr_en(wr_en), .Data(data8), .S_EN(s_en8),
        .Digit_idx(idx8), .Frame_done(fd8), .Pending(pend8)
    );

    seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(8)) dut4 (
        .Clk(clk), .Rst(rst4), .Disp_data(disp_data), .Dp_mask(dp_mask),
        .Blank_mask(blank_mask), .Wr_en(wr4), .Data(data4), .S_EN(s_en4),
        .Digit_idx(idx4), .Frame_done(fd4), .Pending(pend4)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sen(input bit which, output int n);
        n = 0;
        while (n < 40) begin
            tick_clk();
            n++;
            if (which ? s_en4 : s_en8) break;
        end
        if (!(which ? s_en4 : s_en8)) begin
            checks++;
            failures++;
            $display("FAIL sen_timeout dut%0d got no S_EN after %0d cycles, required within 40",
                     which ? 4 : 8, n);
        end
    endtask

    task automatic write8(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        disp_data = d; dp_mask = dp; blank_mask = bl; wr_en = 1'b1;
        tick_clk();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) tick_clk();
        checks++; if (data8 !== 16'hFFFF) begin failures++; $display("FAIL reset_data got=%h exp=ffff", data8); end
        checks++; if (s_en8 !== 1'b0) begin failures++; $display("FAIL reset_sen got=%b exp=0", s_en8); end
        checks++; if (fd8 !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd8); end
        checks++; if (idx8 !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx8); end
        checks++; if (pend8 !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pend8); end
        rst = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick_clk();
            checks++;
            if (s_en8 !== 1'b0 || data8 !== 16'hFFFF) begin
                failures++;
                $display("FAIL pre_first_sen cycle %0d got s_en=%b data=%h exp s_en=0 data=ffff", k, s_en8, data8);
            end
        end
        tick_clk();
        checks++;
        if (s_en8 !== 1'b1 || data8 !== 16'hC0FE || idx8 !== 3'd0 || fd8 !== 1'b0) begin
            failures++;
            $display("FAIL first_sen got s_en=%b data=%h idx=%0d fd=%b exp 1/c0fe/0/0", s_en8, data8, idx8, fd8);
        end
        for (int i = 1; i <= 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (n != 8 || idx8 !== 3'(i % 8) || fd8 !== (i % 8 == 7) ||
                data8 !== {8'hC0, SEL_TBL[i % 8]}) begin
                failures++;
                $display("FAIL scan_seq slot %0d got period=%0d idx=%0d fd=%b data=%h exp period=8 idx=%0d fd=%b data=%h",
                         i, n, idx8, fd8, data8, i % 8, (i % 8 == 7), {8'hC0, SEL_TBL[i % 8]});
            end
        end
    endtask

    task automatic test_write_commit();
        int n;
        logic [15:0] exp [8] = '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7,
                                 16'h99EF, 16'h92DF, 16'h82BF, 16'hF87F};
        write8(32'h76543210, 8'h00, 8'h00);
        checks++; if (pend8 !== 1'b1) begin failures++; $display("FAIL write_pending got=%b exp=1", pend8); end
        for (int i = 1; i < 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (data8 !== {8'hC0, SEL_TBL[i]} || idx8 !== 3'(i)) begin
                failures++;
                $display("FAIL old_frame digit %0d got data=%h idx=%0d exp data=%h", i, data8, idx8, {8'hC0, SEL_TBL[i]});
            end
        end
        for (int i = 0; i < 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (data8 !== exp[i] || idx8 !== 3'(i) || fd8 !== (i == 7)) begin
                failures++;
                $display("FAIL new_frame digit %0d got data=%h idx=%0d fd=%b exp data=%h", i, data8, idx8, fd8, exp[i]);
            end
            if (i == 0) begin
                checks++;
                if (pend8 !== 1'b0) begin failures++; $display("FAIL commit_pending got=%b exp=0", pend8); end
            end
        end
    endtask

    task automatic test_dp_blank();
        int n;
        logic [15:0] exp [8] = '{16'h00FE, 16'h90FD, 16'h88FB, 16'h83F7,
                                 16'hC6EF, 16'hA1DF, 16'h86BF, 16'hFF7F};
        write8(32'hFEDCBA98, 8'h01, 8'h80);
        for (int i = 0; i < 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (data8 !== exp[i] || idx8 !== 3'(i)) begin
                failures++;
                $display("FAIL dp_blank digit %0d got data=%h idx=%0d exp data=%h", i, data8, idx8, exp[i]);
            end
        end
    endtask

    task automatic test_two_writes();
        int n;
        write8(32'h11111111, 8'h00, 8'h00);
        tick_clk();
        write8(32'h22222222, 8'h00, 8'h00);
        checks++; if (pend8 !== 1'b1) begin failures++; $display("FAIL two_writes_pending got=%b exp=1", pend8); end
        for (int i = 0; i < 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (data8 !== {8'hA4, SEL_TBL[i]}) begin
                failures++;
                $display("FAIL two_writes digit %0d got data=%h exp data=%h", i, data8, {8'hA4, SEL_TBL[i]});
            end
        end
    endtask

    task automatic test_write_on_commit();
        int n;
        // Entered right after digit 7's S_EN; the commit tick is 8 edges later.
        write8(32'h33333333, 8'h00, 8'h00);
        repeat (6) tick_clk();
        disp_data = 32'h44444444; wr_en = 1'b1;
        tick_clk();
        wr_en = 1'b0;
        checks++;
        if (s_en8 !== 1'b1 || idx8 !== 3'd0 || data8 !== 16'hB0FE) begin
            failures++;
            $display("FAIL commit_edge got s_en=%b idx=%0d data=%h exp 1/0/b0fe", s_en8, idx8, data8);
        end
        checks++; if (pend8 !== 1'b1) begin failures++; $display("FAIL commit_edge_pending got=%b exp=1", pend8); end
        for (int i = 1; i < 8; i++) begin
            wait_sen(1'b0, n);
            checks++;
            if (data8 !== {8'hB0, SEL_TBL[i]}) begin
                failures++;
                $display("FAIL commit_edge_frame digit %0d got data=%h exp data=%h", i, data8, {8'hB0, SEL_TBL[i]});
            end
        end
        wait_sen(1'b0, n);
        checks++;
        if (data8 !== 16'h99FE || idx8 !== 3'd0) begin
            failures++;
            $display("FAIL late_commit got data=%h idx=%0d exp data=99fe idx=0", data8, idx8);
        end
        checks++; if (pend8 !== 1'b0) begin failures++; $display("FAIL late_commit_pending got=%b exp=0", pend8); end
    endtask

    task automatic test_digits4_reset();
        int n;
        logic [15:0] exp_d [5] = '{16'hC0FE, 16'hC0FD, 16'hC0FB, 16'hC0F7, 16'hC0FE};
        logic [2:0]  exp_i [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic        exp_f [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst4 = 1'b0;
        wait_sen(1'b1, n);
        wait_sen(1'b1, n);
        checks++;
        if (n != 8 || idx4 !== 3'd1 || data4 !== 16'hC0FD) begin
            failures++;
            $display("FAIL d4_pre_reset got period=%0d idx=%0d data=%h exp 8/1/c0fd", n, idx4, data4);
        end
        repeat (3) tick_clk();
        disp_data = 32'h55555555; wr4 = 1'b1;
        tick_clk();
        wr4 = 1'b0;
        checks++; if (pend4 !== 1'b1) begin failures++; $display("FAIL d4_write_pending got=%b exp=1", pend4); end
        repeat (3) tick_clk();
        rst4 = 1'b1;
        tick_clk();
        checks++;
        if (data4 !== 16'hFFFF || s_en4 !== 1'b0 || idx4 !== 3'd0 || fd4 !== 1'b0 || pend4 !== 1'b0) begin
            failures++;
            $display("FAIL d4_mid_reset got data=%h s_en=%b idx=%0d fd=%b pend=%b exp ffff/0/0/0/0",
                     data4, s_en4, idx4, fd4, pend4);
        end
        rst4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_sen(1'b1, n);
            checks++;
            if (n != 8 || data4 !== exp_d[i] || idx4 !== exp_i[i] || fd4 !== exp_f[i]) begin
                failures++;
                $display("FAIL d4_scan slot %0d got period=%0d data=%h idx=%0d fd=%b exp period=8 data=%h idx=%0d fd=%b",
                         i, n, data4, idx4, fd4, exp_d[i], exp_i[i], exp_f[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_dp_blank();
        test_two_writes();
        test_write_on_commit();
        test_digits4_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
